// File: rtl/rgb_seq_ctrl.sv
// rgb_seq_ctrl: lock/reset-request driven bring-up sequencer for the RGB->RGBW pipeline.
// Build option RGB_SEQ_AUTO_RECOVER_EN adds a DRAIN state that re-runs the sequence after overflow.
//
// state     | meaning
// WAIT_LOCK | PLL not locked, every stage held in reset
// HOLD      | locked (or reset requested), all resets held RST_HOLD_CLKS
// REL_OUT   | sotp and FIFO read side released
// REL_FIFO  | FIFO write side released
// REL_IN    | sbit2wrd and sinp released
// RUN       | pipeline live, ready high, heartbeat running
// DRAIN     | (optional) overflow seen, waiting for stream reset with FIFO empty
module rgb_seq_ctrl #(
    parameter int unsigned RST_HOLD_CLKS  = 96,
    parameter int unsigned STAGE_GAP_CLKS = 16,
    parameter int unsigned DEBOUNCE_CLKS  = 96000,
    parameter int unsigned HEARTBEAT_CLKS = 48000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       ext_rst_h,
    input  logic       in_ovflw,
    input  logic       in_stream_reset,
    input  logic       in_rd_fifo_empty,
    output logic       si_rst,
    output logic       s2wd_rst,
    output logic       w_rst,
    output logic       r_rst,
    output logic       so_rst,
    output logic       ready,
    output logic       ovflw_flag,
    output logic       locked_out,
    output logic [3:0] led_red,
    output logic       led_green
);

    localparam int unsigned SEQ_MAX = (RST_HOLD_CLKS > STAGE_GAP_CLKS) ? RST_HOLD_CLKS : STAGE_GAP_CLKS;
    localparam int SEQ_W = $clog2(SEQ_MAX + 1);
    localparam int DEB_W = $clog2(DEBOUNCE_CLKS + 1);
    localparam int HB_W  = $clog2(HEARTBEAT_CLKS + 1);
    localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(RST_HOLD_CLKS - 1);
    localparam logic [SEQ_W-1:0] GAP_LAST  = SEQ_W'(STAGE_GAP_CLKS - 1);
    localparam logic [DEB_W-1:0] DEB_MAX   = DEB_W'(DEBOUNCE_CLKS);
    localparam logic [HB_W-1:0]  HB_LAST   = HB_W'(HEARTBEAT_CLKS - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_REL_OUT   = 3'd2,
        ST_REL_FIFO  = 3'd3,
        ST_REL_IN    = 3'd4,
        ST_RUN       = 3'd5
`ifdef RGB_SEQ_AUTO_RECOVER_EN
        , ST_DRAIN   = 3'd6
`endif
    } state_t;

    state_t           r_state, w_nxt_state;
    logic [SEQ_W-1:0] r_seq_cnt;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [HB_W-1:0]  r_hb_cnt;
    logic             r_lock_s1, r_lock_s2, r_ext_s1, r_ext_s2;
    logic             r_deb_q, r_ovflw, r_ready, r_led_green;
    logic [4:0]       r_rst_vec;           // {si, s2wd, w, r, so}
    logic [3:0]       r_led_red;
    logic             w_lock, w_deb_lvl, w_rst_req, w_ovf_evt, w_seq_clr, w_seq_timed;
    logic [4:0]       w_rst_vec;
    logic [3:0]       w_led_red;
    logic             w_ready;

    assign w_lock    = r_lock_s2;
    assign w_deb_lvl = (r_deb_cnt == DEB_MAX);
    assign w_rst_req = w_deb_lvl & ~r_deb_q & (r_state != ST_WAIT_LOCK);
    assign w_ovf_evt = in_ovflw & ~r_rst_vec[3];

`ifndef RGB_SEQ_AUTO_RECOVER_EN
    logic w_unused_drain_in;
    assign w_unused_drain_in = &{1'b0, in_stream_reset, in_rd_fifo_empty};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_s1 <= 1'b0;
            r_lock_s2 <= 1'b0;
            r_ext_s1  <= 1'b0;
            r_ext_s2  <= 1'b0;
            r_deb_cnt <= '0;
            r_deb_q   <= 1'b0;
        end else begin
            r_lock_s1 <= pll_locked;
            r_lock_s2 <= r_lock_s1;
            r_ext_s1  <= ext_rst_h;
            r_ext_s2  <= r_ext_s1;
            if (!r_ext_s2)
                r_deb_cnt <= '0;
            else if (!w_deb_lvl)
                r_deb_cnt <= r_deb_cnt + 1'b1;
            r_deb_q <= w_deb_lvl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT_LOCK;
            r_seq_cnt <= '0;
        end else begin
            r_state <= w_nxt_state;
            if (w_seq_clr)
                r_seq_cnt <= '0;
            else if (w_seq_timed)
                r_seq_cnt <= r_seq_cnt + 1'b1;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_seq_timed = (r_state == ST_HOLD) || (r_state == ST_REL_OUT) ||
                      (r_state == ST_REL_FIFO) || (r_state == ST_REL_IN);
        // lock loss outranks a reset request, which outranks normal sequencing
        if (!w_lock)
            w_nxt_state = ST_WAIT_LOCK;
        else if (w_rst_req)
            w_nxt_state = ST_HOLD;
        else begin
            case (r_state)
                ST_WAIT_LOCK: w_nxt_state = ST_HOLD;
                ST_HOLD:      if (r_seq_cnt == HOLD_LAST) w_nxt_state = ST_REL_OUT;
                ST_REL_OUT:   if (r_seq_cnt == GAP_LAST)  w_nxt_state = ST_REL_FIFO;
                ST_REL_FIFO:  if (r_seq_cnt == GAP_LAST)  w_nxt_state = ST_REL_IN;
                ST_REL_IN:    if (r_seq_cnt == GAP_LAST)  w_nxt_state = ST_RUN;
`ifdef RGB_SEQ_AUTO_RECOVER_EN
                ST_RUN:       if (w_ovf_evt) w_nxt_state = ST_DRAIN;
                ST_DRAIN:     if (in_stream_reset && in_rd_fifo_empty) w_nxt_state = ST_HOLD;
`endif
                default:      w_nxt_state = r_state;
            endcase
        end
        w_seq_clr = (w_nxt_state != r_state) || w_rst_req;
    end

    // outputs decoded from the next state so they change on the same edge as the state
    always_comb begin
        w_rst_vec = 5'b11111;
        w_led_red = 4'b0001;
        w_ready   = 1'b0;
        case (w_nxt_state)
            ST_HOLD:     w_led_red = 4'b0010;
            ST_REL_OUT:  begin w_rst_vec = 5'b11100; w_led_red = 4'b0100; end
            ST_REL_FIFO: begin w_rst_vec = 5'b11000; w_led_red = 4'b0110; end
            ST_REL_IN:   begin w_rst_vec = 5'b00000; w_led_red = 4'b1000; end
            ST_RUN:      begin w_rst_vec = 5'b00000; w_led_red = 4'b1100; w_ready = 1'b1; end
`ifdef RGB_SEQ_AUTO_RECOVER_EN
            ST_DRAIN:    begin w_rst_vec = 5'b00000; w_led_red = 4'b1110; end
`endif
            default:     w_led_red = 4'b0001;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_vec   <= 5'b11111;
            r_led_red   <= 4'b0001;
            r_ready     <= 1'b0;
            r_ovflw     <= 1'b0;
            r_hb_cnt    <= '0;
            r_led_green <= 1'b0;
        end else begin
            r_rst_vec <= w_rst_vec;
            r_led_red <= w_led_red;
            r_ready   <= w_ready;
            if (w_rst_req && w_lock)
                r_ovflw <= 1'b0;
            else if (w_ovf_evt)
                r_ovflw <= 1'b1;
            if (w_nxt_state != ST_RUN) begin
                r_hb_cnt    <= '0;
                r_led_green <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (r_hb_cnt == HB_LAST) begin
                    r_hb_cnt    <= '0;
                    r_led_green <= ~r_led_green;
                end else begin
                    r_hb_cnt <= r_hb_cnt + 1'b1;
                end
            end
        end
    end

    assign si_rst     = r_rst_vec[4];
    assign s2wd_rst   = r_rst_vec[3];
    assign w_rst      = r_rst_vec[2];
    assign r_rst      = r_rst_vec[1];
    assign so_rst     = r_rst_vec[0];
    assign ready      = r_ready;
    assign ovflw_flag = r_ovflw;
    assign locked_out = r_lock_s2;
    assign led_red    = r_led_red;
    assign led_green  = r_led_green;

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Randomized bench for rgb_seq_ctrl against a timeline model: the sequence is tracked as
// cycles elapsed since entering HOLD, and every output is derived from that elapsed time.
module tb_rgb_seq_ctrl;

    localparam int H  = 8;
    localparam int G  = 4;
    localparam int D  = 10;
    localparam int HB = 20;
`ifdef RGB_SEQ_AUTO_RECOVER_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b1;
    logic       ext_rst_h = 1'b0;
    logic       in_ovflw = 1'b0;
    logic       in_stream_reset = 1'b0;
    logic       in_rd_fifo_empty = 1'b0;
    logic       si_rst, s2wd_rst, w_rst, r_rst, so_rst;
    logic       ready, ovflw_flag, locked_out, led_green;
    logic [3:0] led_red;

    always #5 clk = ~clk;

    rgb_seq_ctrl #(
        .RST_HOLD_CLKS (H),
        .STAGE_GAP_CLKS(G),
        .DEBOUNCE_CLKS (D),
        .HEARTBEAT_CLKS(HB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .ext_rst_h       (ext_rst_h),
        .in_ovflw        (in_ovflw),
        .in_stream_reset (in_stream_reset),
        .in_rd_fifo_empty(in_rd_fifo_empty),
        .si_rst          (si_rst),
        .s2wd_rst        (s2wd_rst),
        .w_rst           (w_rst),
        .r_rst           (r_rst),
        .so_rst          (so_rst),
        .ready           (ready),
        .ovflw_flag      (ovflw_flag),
        .locked_out      (locked_out),
        .led_red         (led_red),
        .led_green       (led_green)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit rnd_se = 1'b1;

    // model: m_phase = -1 while waiting for lock, else cycles since entering HOLD
    int m_phase;
    bit m_drain;
    bit m_flag;
    bit m_lk0, m_lk1, m_ex0, m_ex1;
    int m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = -1;
        m_drain = 1'b0;
        m_flag  = 1'b0;
        m_lk0   = 1'b0;
        m_lk1   = 1'b0;
        m_ex0   = 1'b0;
        m_ex1   = 1'b0;
        m_run   = 0;
    endtask

    task automatic model_step();
        bit lock_ok, req, s2_low, ovf, in_run;
        lock_ok = m_lk1;
        req     = (m_run == D) && (m_phase >= 0);
        s2_low  = m_drain || (m_phase >= H + 2 * G);
        ovf     = in_ovflw && s2_low;
        in_run  = !m_drain && (m_phase >= H + 3 * G);
        if (lock_ok && req)
            m_flag = 1'b0;
        else if (ovf)
            m_flag = 1'b1;
        if (!lock_ok) begin
            m_phase = -1;
            m_drain = 1'b0;
        end else if (req) begin
            m_phase = 0;
            m_drain = 1'b0;
        end else if (m_phase < 0) begin
            m_phase = 0;
        end else if (m_drain) begin
            if (in_stream_reset && in_rd_fifo_empty) begin
                m_phase = 0;
                m_drain = 1'b0;
            end
        end else if (AUTO && in_run && ovf) begin
            m_drain = 1'b1;
        end else begin
            m_phase++;
        end
        m_run = m_ex1 ? m_run + 1 : 0;
        m_ex1 = m_ex0;
        m_ex0 = ext_rst_h;
        m_lk1 = m_lk0;
        m_lk0 = pll_locked;
    endtask

    task automatic check_all();
        logic [4:0] e_rst;
        logic [3:0] e_led;
        logic       e_rdy, e_g;
        e_rdy = 1'b0;
        e_g   = 1'b0;
        if (m_phase < 0) begin
            e_rst = 5'b11111; e_led = 4'b0001;
        end else if (m_drain) begin
            e_rst = 5'b00000; e_led = 4'b1110;
        end else if (m_phase < H) begin
            e_rst = 5'b11111; e_led = 4'b0010;
        end else if (m_phase < H + G) begin
            e_rst = 5'b11100; e_led = 4'b0100;
        end else if (m_phase < H + 2 * G) begin
            e_rst = 5'b11000; e_led = 4'b0110;
        end else if (m_phase < H + 3 * G) begin
            e_rst = 5'b00000; e_led = 4'b1000;
        end else begin
            e_rst = 5'b00000; e_led = 4'b1100; e_rdy = 1'b1;
            e_g   = 1'(((m_phase - (H + 3 * G)) / HB) % 2);
        end
        chk("stage_resets", {si_rst, s2wd_rst, w_rst, r_rst, so_rst}, e_rst);
        chk("led_red", led_red, e_led);
        chk("ready", ready, e_rdy);
        chk("led_green", led_green, e_g);
        chk("ovflw_flag", ovflw_flag, m_flag);
        chk("locked_out", locked_out, m_lk1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (rnd_se) begin
            in_stream_reset  = ($urandom_range(0, 3) == 0);
            in_rd_fifo_empty = $urandom_range(0, 1) == 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic ovf_pulse();
        in_ovflw = 1'b1;
        cyc();
        in_ovflw = 1'b0;
    endtask

    task automatic ext_pulse(input int n);
        ext_rst_h = 1'b1;
        run(n);
        ext_rst_h = 1'b0;
    endtask

    initial begin
        int act;
        model_reset();
        #1 rst_n = 1'b0;
        #3 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // full bring-up and several heartbeat periods
        run(80);
        // lock loss in RUN and re-lock
        pll_locked = 1'b0;
        run(6);
        pll_locked = 1'b1;
        run(50);
        // overflow while sinp/sbit2wrd are still in reset is ignored
        pll_locked = 1'b0;
        run(4);
        pll_locked = 1'b1;
        run(6);
        ovf_pulse();
        run(40);
        // sticky overflow in RUN
        ovf_pulse();
        run(1000);
        // 9 synced-high clocks: no request; 30: exactly one request
        ext_pulse(9);
        run(10);
        ext_pulse(30);
        run(50);

`ifdef RGB_SEQ_AUTO_RECOVER_EN
        rnd_se = 1'b0;
        in_stream_reset  = 1'b0;
        in_rd_fifo_empty = 1'b0;
        ovf_pulse();
        run(5);
        in_stream_reset = 1'b1;
        cyc();
        in_stream_reset = 1'b0;
        run(5);
        in_stream_reset  = 1'b1;
        in_rd_fifo_empty = 1'b1;
        cyc();
        in_stream_reset  = 1'b0;
        in_rd_fifo_empty = 1'b0;
        run(40);
        rnd_se = 1'b1;
`endif

        for (int k = 0; k < 50; k++) begin
            act = $urandom_range(0, 4);
            case (act)
                0: begin
                    pll_locked = 1'b0;
                    run($urandom_range(1, 6));
                    pll_locked = 1'b1;
                end
                1: ext_pulse($urandom_range(1, 25));
                2: ovf_pulse();
                3: ;
                default: async_reset();
            endcase
            run($urandom_range(5, 60));
        end
        run(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
